// File: rtl/adder_share_pkg.sv
// Shared types and constants for the digit-serial shared-adder controller.
package adder_share_pkg;
  localparam int DIGIT_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/adder_slice2.sv
// Combinational 2-bit adder slice; the single shared arithmetic resource.
module adder_slice2
  import adder_share_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               ci,
  output logic [DIGIT_W-1:0] s,
  output logic               co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, ci};
endmodule

// File: rtl/adder_share_ctrl.sv
// Round-robin arbiter plus digit-serial sequencer driving one shared 2-bit adder
// slice, LSB digit first, with a valid/ready response channel.
module adder_share_ctrl
  import adder_share_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             Resetn,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             busy
);
  localparam int DIGITS = WIDTH / DIGIT_W;
  localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t             state_reg, state_next;
  logic               ptr_reg, ptr_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               carry_reg, carry_next;
  logic [WIDTH-1:0]   a_reg, a_next;
  logic [WIDTH-1:0]   b_reg, b_next;
  logic [WIDTH-1:0]   sum_reg, sum_next;
  logic               id_reg, id_next;

  logic               grant0, grant1;
  logic [WIDTH-1:0]   a_sh, b_sh, sum_upd;
  logic [DIGIT_W-1:0] slice_s;
  logic               slice_co;

  // On contention the pointer names the winner; a lone requester always wins.
  assign grant0 = req0_valid && (!req1_valid || !ptr_reg);
  assign grant1 = req1_valid && (!req0_valid ||  ptr_reg);

  assign a_sh = a_reg >> {cnt_reg, 1'b0};
  assign b_sh = b_reg >> {cnt_reg, 1'b0};

  adder_slice2 u_slice (
    .a  (a_sh[DIGIT_W-1:0]),
    .b  (b_sh[DIGIT_W-1:0]),
    .ci (carry_reg),
    .s  (slice_s),
    .co (slice_co)
  );

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign sum_upd[gi*DIGIT_W +: DIGIT_W] =
        (cnt_reg == CNT_W'(gi)) ? slice_s : sum_reg[gi*DIGIT_W +: DIGIT_W];
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (Resetn) begin
      state_reg <= IDLE;
      ptr_reg   <= 1'b0;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      id_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
      carry_reg <= carry_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      sum_reg   <= sum_next;
      id_reg    <= id_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;
    carry_next = carry_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    sum_next   = sum_reg;
    id_next    = id_reg;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_reg)
      IDLE: begin
        req0_ready = grant0;
        req1_ready = grant1;
        if (grant0 || grant1) begin
          a_next     = grant1 ? req1_a   : req0_a;
          b_next     = grant1 ? req1_b   : req0_b;
          carry_next = grant1 ? req1_cin : req0_cin;
          id_next    = grant1;
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        sum_next   = sum_upd;
        carry_next = slice_co;
        cnt_next   = cnt_reg + 1'b1;
        if (cnt_reg == CNT_W'(DIGITS - 1)) state_next = DONE;
      end
      DONE: begin
        // The response handshake alone ends DONE; no grant is offered this cycle.
        if (rsp_ready) begin
          state_next = IDLE;
          ptr_next   = ~id_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign rsp_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign rsp_id    = id_reg;
  assign rsp_sum   = sum_reg;
  assign rsp_cout  = carry_reg;
endmodule

// File: tb/tb_adder_share_ctrl.sv
// Directed bench for adder_share_ctrl: an 8-bit instance for arbitration,
// backpressure and abort, plus a 2-bit instance for the single-digit case.
module tb_adder_share_ctrl;
  logic       CLK = 1'b0;
  logic       Resetn = 1'b1;
  logic       req0_valid = 0, req1_valid = 0, rsp_ready = 0;
  logic [7:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic       req0_cin = 0, req1_cin = 0;
  logic       req0_ready, req1_ready, rsp_valid, rsp_id, rsp_cout, busy;
  logic [7:0] rsp_sum;

  logic       d2_req0_valid = 0, d2_rsp_ready = 0;
  logic [1:0] d2_req0_a = 0, d2_req0_b = 0;
  logic       d2_req0_cin = 0;
  logic       d2_req0_ready, d2_req1_ready, d2_rsp_valid, d2_rsp_id, d2_rsp_cout, d2_busy;
  logic [1:0] d2_rsp_sum;
  logic       d2_req1_valid = 0, d2_req1_cin = 0;
  logic [1:0] d2_req1_a = 0, d2_req1_b = 0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 CLK = ~CLK;

  adder_share_ctrl #(.WIDTH(8)) dut (
    .CLK(CLK), .Resetn(Resetn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_cout(rsp_cout), .busy(busy)
  );

  adder_share_ctrl #(.WIDTH(2)) dut2 (
    .CLK(CLK), .Resetn(Resetn),
    .req0_valid(d2_req0_valid), .req0_ready(d2_req0_ready), .req0_a(d2_req0_a), .req0_b(d2_req0_b), .req0_cin(d2_req0_cin),
    .req1_valid(d2_req1_valid), .req1_ready(d2_req1_ready), .req1_a(d2_req1_a), .req1_b(d2_req1_b), .req1_cin(d2_req1_cin),
    .rsp_valid(d2_rsp_valid), .rsp_ready(d2_rsp_ready), .rsp_id(d2_rsp_id), .rsp_sum(d2_rsp_sum),
    .rsp_cout(d2_rsp_cout), .busy(d2_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
      $display("check %s: got %0h want %0h", tag, obs, exp);
    end else begin
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Counts edges from a transfer until rsp_valid, bounded to 10.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < 10) begin
      step();
      cyc++;
      if (rsp_valid) break;
    end
  endtask

  int   cyc;
  logic seen;
  logic [7:0] held_sum;

  initial begin
    step(); step();
    Resetn = 1'b0;
    step();
    // Reset / idle state
    check("idle_rdy0", req0_ready, 0);
    check("idle_rdy1", req1_ready, 0);
    check("idle_rsp_valid", rsp_valid, 0);
    check("idle_busy", busy, 0);
    check("idle_sum", rsp_sum, 8'h00);

    // A5 + 5A + 1 from req0
    req0_valid = 1; req0_a = 8'hA5; req0_b = 8'h5A; req0_cin = 1;
    #1;
    check("grant0_comb", req0_ready, 1);
    check("grant0_only", req1_ready, 0);
    step();
    req0_valid = 0;
    check("run_busy", busy, 1);
    check("run_rdy0", req0_ready, 0);
    wait_done(cyc);
    check("lat_a5", cyc, 4);
    check("sum_a5", rsp_sum, 8'h00);
    check("cout_a5", rsp_cout, 1);
    check("id_a5", rsp_id, 0);
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    check("post_hs_valid", rsp_valid, 0);
    check("post_hs_busy", busy, 0);

    // Abort: req1 starts, reset lands on its second RUN edge (pointer is 1 here)
    req1_valid = 1; req1_a = 8'h33; req1_b = 8'h44; req1_cin = 0;
    #1;
    check("abort_grant1", req1_ready, 1);
    step();
    req1_valid = 0;
    step();
    Resetn = 1'b1;
    step();
    Resetn = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", rsp_valid, 0);
    check("abort_sum", rsp_sum, 8'h00);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (rsp_valid) seen = 1;
    end
    check("abort_no_rsp", seen, 0);

    // Both valid after reset: req0 wins
    req0_valid = 1; req0_a = 8'h01; req0_b = 8'h02; req0_cin = 0;
    req1_valid = 1; req1_a = 8'hFF; req1_b = 8'h01; req1_cin = 0;
    #1;
    check("both_rdy0", req0_ready, 1);
    check("both_rdy1", req1_ready, 0);
    step();
    wait_done(cyc);
    check("lat_both", cyc, 4);
    check("sum_both", rsp_sum, 8'h03);
    check("id_both", rsp_id, 0);

    // Backpressure for 5 cycles in DONE
    held_sum = rsp_sum;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid", rsp_valid, 1);
      check("bp_sum", rsp_sum, 8'h03);
      check("bp_rdys", {req0_ready, req1_ready}, 2'b00);
    end
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    check("bp_hs_valid", rsp_valid, 0);
    check("rr_rdy1", req1_ready, 1);
    check("rr_rdy0", req0_ready, 0);
    step();
    wait_done(cyc);
    check("lat_ff", cyc, 4);
    check("sum_ff", rsp_sum, 8'h00);
    check("cout_ff", rsp_cout, 1);
    check("id_ff", rsp_id, 1);
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    check("rr_back_rdy0", req0_ready, 1);
    check("rr_back_rdy1", req1_ready, 0);
    req0_valid = 0; req1_valid = 0;

    // WIDTH=2: 3 + 3 + 1 = 7
    d2_req0_valid = 1; d2_req0_a = 2'b11; d2_req0_b = 2'b11; d2_req0_cin = 1;
    #1;
    check("w2_rdy", d2_req0_ready, 1);
    step();
    d2_req0_valid = 0;
    check("w2_run_valid", d2_rsp_valid, 0);
    step();
    check("w2_valid", d2_rsp_valid, 1);
    check("w2_sum", d2_rsp_sum, 2'b11);
    check("w2_cout", d2_rsp_cout, 1);
    check("w2_id", d2_rsp_id, 0);
    d2_rsp_ready = 1;
    step();
    d2_rsp_ready = 0;
    check("w2_idle", d2_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
